// File: rtl/mm_pkg.sv
// Shared types and constants for the mastermind game-level control blocks.
package mm_pkg;

    localparam int unsigned SCORE_W = 2;

    localparam int unsigned WIN_POINTS_MIN = 1;
    localparam int unsigned WIN_POINTS_MAX = 3;
    localparam int unsigned MAX_ROUNDS_MIN = 1;
    localparam int unsigned MAX_ROUNDS_MAX = 3;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_A    = 2'b01;
    localparam logic [1:0] WIN_B    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAKE_REQ,
        S_MAKE_WAIT,
        S_BREAK_REQ,
        S_BREAK_WAIT,
        S_CHECK,
        S_GAME_OVER
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == '1) ? v : SCORE_W'(v + 1'b1);
    endfunction

endpackage

// File: rtl/game_sequencer_score_keeper.sv
// Score and round bookkeeping: saturating counters, end-of-game test, winner encode.
module score_keeper
    import mm_pkg::*;
#(
    parameter int unsigned WIN_POINTS = 2,
    parameter int unsigned MAX_ROUNDS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               score_en,
    input  logic               point_to_a,
    input  logic               latch_winner,
    output logic [SCORE_W-1:0] points_a,
    output logic [SCORE_W-1:0] points_b,
    output logic [SCORE_W-1:0] round_counter,
    output logic [1:0]         winner,
    output logic               game_end_c
);

    logic [1:0] winner_code_c;

    assign game_end_c = (points_a == SCORE_W'(WIN_POINTS)) ||
                        (points_b == SCORE_W'(WIN_POINTS)) ||
                        (round_counter == SCORE_W'(MAX_ROUNDS));

    always_comb begin
        winner_code_c = WIN_DRAW;
        if (points_a > points_b) begin
            winner_code_c = WIN_A;
        end else if (points_b > points_a) begin
            winner_code_c = WIN_B;
        end
    end

    // Scores hold through GAME_OVER for display; only a new game clears them.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            points_a      <= '0;
            points_b      <= '0;
            round_counter <= '0;
            winner        <= WIN_NONE;
        end else begin
            if (score_en) begin
                if (point_to_a) begin
                    points_a <= sat_inc(points_a);
                end else begin
                    points_b <= sat_inc(points_b);
                end
                round_counter <= sat_inc(round_counter);
            end
            if (latch_winner) begin
                winner <= winner_code_c;
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Round scheduler: assigns roles, sequences maker/breaker phases, scores rounds, ends the game.
module game_sequencer
    import mm_pkg::*;
#(
    parameter int unsigned WIN_POINTS = 2,
    parameter int unsigned MAX_ROUNDS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               first_maker_A,
    input  logic               maker_done,
    input  logic               breaker_done,
    input  logic               breaker_won,
    output logic               maker_start,
    output logic               breaker_start,
    output logic               maker_is_A,
    output logic [SCORE_W-1:0] pointsOfA,
    output logic [SCORE_W-1:0] pointsOfB,
    output logic [SCORE_W-1:0] round_counter,
    output logic               busy,
    output logic               game_over,
    output logic [1:0]         winner
);

    if (WIN_POINTS < WIN_POINTS_MIN || WIN_POINTS > WIN_POINTS_MAX ||
        MAX_ROUNDS < MAX_ROUNDS_MIN || MAX_ROUNDS > MAX_ROUNDS_MAX) begin : g_bad_param
        $error("game_sequencer: WIN_POINTS/MAX_ROUNDS out of legal range");
    end

    state_t state;
    state_t next_state;
    logic   clear_c;
    logic   score_en_c;
    logic   flip_c;
    logic   latch_winner_c;
    logic   game_end_c;
    logic   point_to_a_c;

    // The breaker is B when A makes; a lost break scores for the maker.
    assign point_to_a_c = maker_is_A ^ breaker_won;

    always_comb begin
        next_state     = state;
        clear_c        = 1'b0;
        score_en_c     = 1'b0;
        flip_c         = 1'b0;
        latch_winner_c = 1'b0;
        case (state)
            S_IDLE, S_GAME_OVER: begin
                if (start) begin
                    clear_c    = 1'b1;
                    next_state = S_MAKE_REQ;
                end
            end
            S_MAKE_REQ:  next_state = S_MAKE_WAIT;
            S_MAKE_WAIT: begin
                if (maker_done) begin
                    next_state = S_BREAK_REQ;
                end
            end
            S_BREAK_REQ: next_state = S_BREAK_WAIT;
            S_BREAK_WAIT: begin
                if (breaker_done) begin
                    score_en_c = 1'b1;
                    next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (game_end_c) begin
                    latch_winner_c = 1'b1;
                    next_state     = S_GAME_OVER;
                end else begin
                    flip_c     = 1'b1;
                    next_state = S_MAKE_REQ;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs are registered from next_state so they align with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            maker_is_A    <= 1'b0;
            maker_start   <= 1'b0;
            breaker_start <= 1'b0;
            busy          <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            state         <= next_state;
            maker_start   <= (next_state == S_MAKE_REQ);
            breaker_start <= (next_state == S_BREAK_REQ);
            busy          <= !((next_state == S_IDLE) || (next_state == S_GAME_OVER));
            game_over     <= (next_state == S_GAME_OVER);
            if (clear_c) begin
                maker_is_A <= first_maker_A;
            end else if (flip_c) begin
                maker_is_A <= !maker_is_A;
            end
        end
    end

    score_keeper #(
        .WIN_POINTS (WIN_POINTS),
        .MAX_ROUNDS (MAX_ROUNDS)
    ) u_score_keeper (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear_c),
        .score_en      (score_en_c),
        .point_to_a    (point_to_a_c),
        .latch_winner  (latch_winner_c),
        .points_a      (pointsOfA),
        .points_b      (pointsOfB),
        .round_counter (round_counter),
        .winner        (winner),
        .game_end_c    (game_end_c)
    );

endmodule
